// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: funct3 encodings,
// the default operand width and a helper that flags reserved encodings.
package branch_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    // 010 and 011 are unused in the conditional-branch opcode space
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator for branch resolution: equality, signed less-than and
// unsigned less-than. Purely combinational.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    logic [XLEN-1:0] bit_match;

    // Per-bit match vector; equality is the AND-reduction of all bits
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit_match
            assign bit_match[gi] = ~(rs1_data[gi] ^ rs2_data[gi]);
        end
    endgenerate

    // Flags are always produced, regardless of which condition is selected
    always_comb begin
        eq  = &bit_match;
        lt  = $signed(rs1_data) < $signed(rs2_data);
        ltu = rs1_data < rs2_data;
    end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage conditional branch resolution. The decision and compare
// flags are combinational so the PC-select mux can use them in the same
// cycle; the last valid decision is also held in registers.
// Optional statistics counters are built when BRANCH_STATS_EN is defined;
// otherwise the counter outputs are constant zero and no counter flops exist.
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [2:0]       funct3_i,
    input  logic             valid_i,
    output logic             branch_taken_o,
    output logic             branch_eq_o,
    output logic             branch_lt_o,
    output logic             branch_ltu_o,
    output logic             illegal_o,
    output logic             taken_q_o,
    output logic             illegal_q_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] taken_count_o
);

    logic    eq, lt, ltu;
    funct3_e f3;
    logic    taken_q_reg, taken_q_next;
    logic    illegal_q_reg, illegal_q_next;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1_data (rs1_data_i),
        .rs2_data (rs2_data_i),
        .eq       (eq),
        .lt       (lt),
        .ltu      (ltu)
    );

    assign f3 = funct3_e'(funct3_i);

    // Condition select: reserved encodings fall to default and never branch
    always_comb begin
        branch_taken_o = 1'b0;
        illegal_o      = is_illegal_f3(funct3_i);
        case (f3)
            F3_BEQ:  branch_taken_o = eq;
            F3_BNE:  branch_taken_o = ~eq;
            F3_BLT:  branch_taken_o = lt;
            F3_BGE:  branch_taken_o = ~lt;
            F3_BLTU: branch_taken_o = ltu;
            F3_BGEU: branch_taken_o = ~ltu;
            default: branch_taken_o = 1'b0;
        endcase
    end

    assign branch_eq_o  = eq;
    assign branch_lt_o  = lt;
    assign branch_ltu_o = ltu;

    // Capture the decision of a valid branch, otherwise hold
    always_comb begin
        taken_q_next   = taken_q_reg;
        illegal_q_next = illegal_q_reg;
        if (valid_i) begin
            taken_q_next   = branch_taken_o;
            illegal_q_next = illegal_o;
        end
    end

    // Decision register; reset wins over a simultaneous valid branch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taken_q_reg   <= 1'b0;
            illegal_q_reg <= 1'b0;
        end else begin
            taken_q_reg   <= taken_q_next;
            illegal_q_reg <= illegal_q_next;
        end
    end

    assign taken_q_o   = taken_q_reg;
    assign illegal_q_o = illegal_q_reg;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_count_reg, br_count_next;
    logic [CNT_W-1:0] taken_count_reg, taken_count_next;

    // Counters wrap naturally at 2^CNT_W
    always_comb begin
        br_count_next    = br_count_reg;
        taken_count_next = taken_count_reg;
        if (valid_i) begin
            br_count_next = br_count_reg + 1'b1;
            if (branch_taken_o) begin
                taken_count_next = taken_count_reg + 1'b1;
            end
        end
    end

    // Statistics registers, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_count_reg    <= '0;
            taken_count_reg <= '0;
        end else begin
            br_count_reg    <= br_count_next;
            taken_count_reg <= taken_count_next;
        end
    end

    assign br_count_o    = br_count_reg;
    assign taken_count_o = taken_count_reg;
`else
    assign br_count_o    = '0;
    assign taken_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, hand-written
// registered-path sequences, then randomized traffic against a reference
// model built from the branch rules with plain integer arithmetic.
module tb_branch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [2:0]       funct3;
    logic             valid;
    logic             taken;
    logic             eq_o;
    logic             lt_o;
    logic             ltu_o;
    logic             illegal;
    logic             taken_q;
    logic             illegal_q;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic        m_taken_q;
    logic        m_illegal_q;
    logic [31:0] m_br_cnt;
    logic [31:0] m_tk_cnt;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        ill;
    } vec_t;

    vec_t vecs[18];

    branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rs1_data_i     (rs1),
        .rs2_data_i     (rs2),
        .funct3_i       (funct3),
        .valid_i        (valid),
        .branch_taken_o (taken),
        .branch_eq_o    (eq_o),
        .branch_lt_o    (lt_o),
        .branch_ltu_o   (ltu_o),
        .illegal_o      (illegal),
        .taken_q_o      (taken_q),
        .illegal_q_o    (illegal_q),
        .br_count_o     (br_count),
        .taken_count_o  (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of the branch rules using integer arithmetic
    task automatic ref_eval(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                            output logic t, output logic e, output logic l,
                            output logic lu, output logic il);
        longint sa, sb, ua, ub;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = a[31] ? ua - 64'sd4294967296 : ua;
        sb = b[31] ? ub - 64'sd4294967296 : ub;
        e  = (ua == ub);
        l  = (sa < sb);
        lu = (ua < ub);
        il = (f3 == 3'd2) || (f3 == 3'd3);
        case (f3)
            3'd0: t = e;
            3'd1: t = !e;
            3'd4: t = l;
            3'd5: t = !l;
            3'd6: t = lu;
            3'd7: t = !lu;
            default: t = 1'b0;
        endcase
    endtask

    function automatic logic [63:0] exp_cnt(input logic [31:0] c);
`ifdef BRANCH_STATS_EN
        return {32'd0, c};
`else
        return (c & 32'd0) == 32'd0 ? 64'd0 : 64'd0;
`endif
    endfunction

    // Advance the reference registered state for one clock edge
    task automatic model_edge(input logic r, input logic v, input logic t, input logic il);
        if (r) begin
            m_taken_q = 1'b0; m_illegal_q = 1'b0; m_br_cnt = 0; m_tk_cnt = 0;
        end else if (v) begin
            m_taken_q = t; m_illegal_q = il;
            m_br_cnt = m_br_cnt + 1;
            if (t) m_tk_cnt = m_tk_cnt + 1;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".taken_q"},     {63'd0, taken_q},   {63'd0, m_taken_q});
        check({tag, ".illegal_q"},   {63'd0, illegal_q}, {63'd0, m_illegal_q});
        check({tag, ".br_count"},    {32'd0, br_count},    exp_cnt(m_br_cnt));
        check({tag, ".taken_count"}, {32'd0, taken_count}, exp_cnt(m_tk_cnt));
    endtask

    // Apply one cycle: check combinational outputs mid-cycle, then the
    // registered outputs just after the following rising edge
    task automatic cycle(input string tag, input logic r, input logic v,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic t, e, l, lu, il;
        @(negedge clk);
        rst = r; valid = v; funct3 = f3; rs1 = a; rs2 = b;
        #1;
        ref_eval(a, b, f3, t, e, l, lu, il);
        check({tag, ".taken"},   {63'd0, taken},   {63'd0, t});
        check({tag, ".illegal"}, {63'd0, illegal}, {63'd0, il});
        check({tag, ".eq"},      {63'd0, eq_o},    {63'd0, e});
        check({tag, ".lt"},      {63'd0, lt_o},    {63'd0, l});
        check({tag, ".ltu"},     {63'd0, ltu_o},   {63'd0, lu});
        @(posedge clk);
        #1;
        model_edge(r, v, t, il);
        check_regs(tag);
    endtask

    initial begin
        int taken_n;
        vecs[0]  = '{3'b000, 32'd10, 32'd10, 1, 1, 0, 0, 0};
        vecs[1]  = '{3'b000, 32'd10, 32'd5,  0, 0, 0, 0, 0};
        vecs[2]  = '{3'b001, 32'd10, 32'd5,  1, 0, 0, 0, 0};
        vecs[3]  = '{3'b001, 32'd10, 32'd10, 0, 1, 0, 0, 0};
        vecs[4]  = '{3'b100, 32'hFFFFFFFB, 32'd10, 1, 0, 1, 0, 0};
        vecs[5]  = '{3'b100, 32'd10, 32'hFFFFFFFB, 0, 0, 0, 1, 0};
        vecs[6]  = '{3'b101, 32'd10, 32'hFFFFFFFB, 1, 0, 0, 1, 0};
        vecs[7]  = '{3'b101, 32'hFFFFFFFB, 32'hFFFFFFFB, 1, 1, 0, 0, 0};
        vecs[8]  = '{3'b101, 32'hFFFFFFF6, 32'd5, 0, 0, 1, 0, 0};
        vecs[9]  = '{3'b110, 32'h0F, 32'h10, 1, 0, 1, 1, 0};
        vecs[10] = '{3'b110, 32'h10, 32'h0F, 0, 0, 0, 0, 0};
        vecs[11] = '{3'b111, 32'h10, 32'h0F, 1, 0, 0, 0, 0};
        vecs[12] = '{3'b111, 32'h0F, 32'h0F, 1, 1, 0, 0, 0};
        vecs[13] = '{3'b111, 32'h0F, 32'h10, 0, 0, 1, 1, 0};
        vecs[14] = '{3'b110, 32'hFFFFFFFF, 32'd0, 0, 0, 1, 0, 0};
        vecs[15] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 1, 0, 1, 0, 0};
        vecs[16] = '{3'b010, 32'd7, 32'd7, 0, 1, 0, 0, 1};
        vecs[17] = '{3'b011, 32'd3, 32'd9, 0, 0, 1, 1, 1};

        m_taken_q = 0; m_illegal_q = 0; m_br_cnt = 0; m_tk_cnt = 0;
        rst = 1'b1; valid = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;

        // Combinational outputs must be valid before any clock activity
        #1;
        check("pre_clk.eq", {63'd0, eq_o}, 64'd1);
        check("pre_clk.taken", {63'd0, taken}, 64'd1);

        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        $display("reset: taken_q=%0b illegal_q=%0b br=%0d tk=%0d", taken_q, illegal_q, br_count, taken_count);

        // Directed table with hand-derived expectations
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst = 0; valid = 1; funct3 = vecs[i].f3; rs1 = vecs[i].a; rs2 = vecs[i].b;
            #1;
            check($sformatf("vec%0d.taken", i),   {63'd0, taken},   {63'd0, vecs[i].taken});
            check($sformatf("vec%0d.eq", i),      {63'd0, eq_o},    {63'd0, vecs[i].eq});
            check($sformatf("vec%0d.lt", i),      {63'd0, lt_o},    {63'd0, vecs[i].lt});
            check($sformatf("vec%0d.ltu", i),     {63'd0, ltu_o},   {63'd0, vecs[i].ltu});
            check($sformatf("vec%0d.illegal", i), {63'd0, illegal}, {63'd0, vecs[i].ill});
            @(posedge clk);
            #1;
            model_edge(1'b0, 1'b1, vecs[i].taken, vecs[i].ill);
            check($sformatf("vec%0d.taken_q", i),   {63'd0, taken_q},   {63'd0, vecs[i].taken});
            check($sformatf("vec%0d.illegal_q", i), {63'd0, illegal_q}, {63'd0, vecs[i].ill});
            check($sformatf("vec%0d.br_count", i),  {32'd0, br_count},  exp_cnt(32'(i + 1)));
            $display("vec %0d: f3=%03b a=%08h b=%08h taken=%0b eq=%0b lt=%0b ltu=%0b ill=%0b",
                     i, vecs[i].f3, vecs[i].a, vecs[i].b, taken, eq_o, lt_o, ltu_o, illegal);
        end

        // Illegal captured, then held across an idle cycle
        cycle("illegal_cap", 0, 1, 3'b010, 32'd4, 32'd4);
        check("illegal_cap.direct", {63'd0, illegal_q}, 64'd1);
        cycle("idle_hold", 0, 0, 3'b000, 32'd1, 32'd1);
        check("idle_hold.direct", {63'd0, illegal_q}, 64'd1);
        $display("seq illegal/hold: illegal_q=%0b taken_q=%0b", illegal_q, taken_q);

        // Taken captured, then reset with valid high must clear
        cycle("taken_cap", 0, 1, 3'b001, 32'd1, 32'd2);
        cycle("rst_prio", 1, 1, 3'b001, 32'd1, 32'd2);
        check("rst_prio.direct", {62'd0, taken_q, illegal_q}, 64'd0);
        $display("seq reset priority: taken_q=%0b illegal_q=%0b", taken_q, illegal_q);

        // Four valid branches, three taken, then an idle cycle
        cycle("st0", 0, 1, 3'b000, 32'd5, 32'd5);
        cycle("st1", 0, 1, 3'b001, 32'd5, 32'd6);
        cycle("st2", 0, 1, 3'b000, 32'd5, 32'd6);
        cycle("st3", 0, 1, 3'b111, 32'd9, 32'd6);
        check("stats.br", {32'd0, br_count}, exp_cnt(32'd4));
        check("stats.tk", {32'd0, taken_count}, exp_cnt(32'd3));
        cycle("st_idle", 0, 0, 3'b000, 32'd5, 32'd5);
        check("stats_idle.br", {32'd0, br_count}, exp_cnt(32'd4));
        check("stats_idle.tk", {32'd0, taken_count}, exp_cnt(32'd3));
        $display("seq stats: br=%0d tk=%0d", br_count, taken_count);

        // Randomized traffic against the model
        taken_n = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            logic [2:0]  f;
            logic        v, r;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h80000000;
                default: b = $urandom;
            endcase
            f = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 40) == 0);
            cycle($sformatf("rnd%0d", i), r, v, f, a, b);
            if (taken) taken_n++;
            $display("rnd %0d: rst=%0b v=%0b f3=%03b a=%08h b=%08h taken=%0b q=%0b",
                     i, r, v, f, a, b, taken, taken_q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
